hist2d_readout: RTL and testbench

//  Reader side of the 2D-histogram count memory. hist2d_count increments bins

---
 rtl/hist2d_readout.sv | 189 ++++++++++++++++++
 tb/tb_hist2d_readout.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist2d_readout.sv
// Scans the 2D-histogram count memory in i-major/q-minor order and streams one
// (i_bin, q_bin, count) word per bin over valid/ready, optionally zeroing each bin after it is sent.
module hist2d_readout #(
    parameter int BIN_BITS    = 6,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk100,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    clear_after,
    input  logic [BIN_BITS-1:0]     i_bin_num,
    input  logic [BIN_BITS-1:0]     q_bin_num,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [2*BIN_BITS-1:0]   mem_addr,
    input  logic [COUNT_WIDTH-1:0]  mem_rd_data,
    output logic                    mem_we,
    output logic [COUNT_WIDTH-1:0]  mem_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_BITS-1:0]     out_i_bin,
    output logic [BIN_BITS-1:0]     out_q_bin,
    output logic [COUNT_WIDTH-1:0]  out_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_CLEAR   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [BIN_BITS-1:0] BIN_ZERO = {BIN_BITS{1'b0}};
    localparam logic [BIN_BITS-1:0] BIN_ONE  = {{(BIN_BITS-1){1'b0}}, 1'b1};

    state_t                   state_r;
    state_t                   state_s;
    logic [BIN_BITS-1:0]      i_r;
    logic [BIN_BITS-1:0]      q_r;
    logic [BIN_BITS-1:0]      i_num_r;
    logic [BIN_BITS-1:0]      q_num_r;
    logic                     clear_r;
    logic [2*BIN_BITS-1:0]    addr_r;
    logic [BIN_BITS-1:0]      out_i_r;
    logic [BIN_BITS-1:0]      out_q_r;
    logic [COUNT_WIDTH-1:0]   out_count_r;
    logic                     last_bin_s;
    logic                     q_wrap_s;
    logic                     advance_s;
    logic [BIN_BITS-1:0]      i_next_s;
    logic [BIN_BITS-1:0]      q_next_s;
    logic                     busy_s;
    logic                     done_s;
    logic                     rd_en_s;
    logic                     we_s;
    logic                     valid_s;

    // Scan position bookkeeping: end-of-scan, row wrap and the next {i,q}.
    always_comb begin
        last_bin_s = (i_r == i_num_r - BIN_ONE) && (q_r == q_num_r - BIN_ONE);
        q_wrap_s   = (q_r == q_num_r - BIN_ONE);
        advance_s  = ((state_r == S_PRESENT) && out_ready && !clear_r) || (state_r == S_CLEAR);
        i_next_s   = i_r;
        q_next_s   = q_r;
        if (state_r == S_IDLE) begin
            i_next_s = BIN_ZERO;
            q_next_s = BIN_ZERO;
        end else if (advance_s && !last_bin_s) begin
            if (q_wrap_s) begin
                i_next_s = i_r + BIN_ONE;
                q_next_s = BIN_ZERO;
            end else begin
                i_next_s = i_r;
                q_next_s = q_r + BIN_ONE;
            end
        end else begin
            i_next_s = i_r;
            q_next_s = q_r;
        end
    end

    // State register.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if ((i_bin_num == BIN_ZERO) || (q_bin_num == BIN_ZERO)) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_READ;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ:    state_s = S_WAIT;
            S_WAIT:    state_s = S_PRESENT;
            S_PRESENT: begin
                if (!out_ready) begin
                    state_s = S_PRESENT;
                end else if (clear_r) begin
                    state_s = S_CLEAR;
                end else if (last_bin_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_READ;
                end
            end
            S_CLEAR:   state_s = last_bin_s ? S_DONE : S_READ;
            S_DONE:    state_s = S_IDLE;
            default:   state_s = S_IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        busy_s  = 1'b1;
        done_s  = 1'b0;
        rd_en_s = 1'b0;
        we_s    = 1'b0;
        valid_s = 1'b0;
        case (state_r)
            S_IDLE:    busy_s  = 1'b0;
            S_READ:    rd_en_s = 1'b1;
            S_WAIT:    busy_s  = 1'b1;
            S_PRESENT: valid_s = 1'b1;
            S_CLEAR:   we_s    = 1'b1;
            S_DONE:    done_s  = 1'b1;
            default:   busy_s  = 1'b0;
        endcase
    end

    // Scan counters, dump configuration, address and output word registers.
    always_ff @(posedge clk100) begin
        if (reset) begin
            i_r         <= BIN_ZERO;
            q_r         <= BIN_ZERO;
            i_num_r     <= BIN_ZERO;
            q_num_r     <= BIN_ZERO;
            clear_r     <= 1'b0;
            addr_r      <= {(2*BIN_BITS){1'b0}};
            out_i_r     <= BIN_ZERO;
            out_q_r     <= BIN_ZERO;
            out_count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            i_r <= i_next_s;
            q_r <= q_next_s;
            if ((state_r == S_IDLE) && start) begin
                i_num_r <= i_bin_num;
                q_num_r <= q_bin_num;
                clear_r <= clear_after;
            end
            // Address only moves when a read or clear is about to use it.
            if ((state_s == S_READ) || (state_s == S_CLEAR)) begin
                addr_r <= {i_next_s, q_next_s};
            end
            if (state_r == S_WAIT) begin
                out_count_r <= mem_rd_data;
                out_i_r     <= i_r;
                out_q_r     <= q_r;
            end
        end
    end

    assign busy      = busy_s;
    assign done      = done_s;
    assign mem_rd_en = rd_en_s;
    assign mem_we    = we_s;
    assign out_valid = valid_s;
    assign mem_addr  = addr_r;
    assign mem_wdata = {COUNT_WIDTH{1'b0}};
    assign out_i_bin = out_i_r;
    assign out_q_bin = out_q_r;
    assign out_count = out_count_r;

endmodule

// File: tb/tb_hist2d_readout.sv
// Directed bench for hist2d_readout: a behavioural count memory, a per-cycle
// sample log, and assertions against hand-computed word sequences and timing.
module tb_hist2d_readout;

    logic        clk100 = 1'b0;
    logic        reset, start, clear_after, out_ready;
    logic [5:0]  i_bin_num, q_bin_num;
    logic        busy, done, mem_rd_en, mem_we, out_valid;
    logic [11:0] mem_addr;
    logic [15:0] mem_rd_data, mem_wdata, out_count;
    logic [5:0]  out_i_bin, out_q_bin;

    always #5 clk100 = ~clk100;

    hist2d_readout #(.BIN_BITS(6), .COUNT_WIDTH(16)) dut (
        .clk100(clk100), .reset(reset), .start(start), .clear_after(clear_after),
        .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_i_bin(out_i_bin), .out_q_bin(out_q_bin),
        .out_count(out_count)
    );

    // Count memory: preload writes 16*i+q everywhere, one-cycle read latency.
    logic [15:0] mem [0:4095];
    logic        preload = 1'b0;
    always @(posedge clk100) begin
        if (preload) begin
            for (int a = 0; a < 4096; a++) mem[a] <= 16'(16 * (a >> 6) + (a & 63));
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    typedef struct {
        int lbl; logic v; logic r; logic rd; logic we; logic dn; logic bz;
        logic [5:0] i; logic [5:0] q; logic [15:0] c; logic [11:0] a;
    } smp_t;
    smp_t log_q[$];
    smp_t words_q[$];
    logic log_en = 1'b0;

    // Each sample is labelled with the clock edge that will act on it.
    always @(negedge clk100) begin
        if (log_en) log_q.push_back('{cyc + 1, out_valid, out_ready, mem_rd_en, mem_we, done, busy,
                                      out_i_bin, out_q_bin, out_count, mem_addr});
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic start_dump(input logic [5:0] ni, input logic [5:0] nq, input logic clr, output int n);
        i_bin_num   = ni;
        q_bin_num   = nq;
        clear_after = clr;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        n           = cyc;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while (busy === 1'b1 && k < limit) begin
            tick();
            k++;
        end
        chk(tag, busy, 0);
        tick();
        tick();
    endtask

    task automatic collect();
        words_q.delete();
        foreach (log_q[k]) if (log_q[k].v && log_q[k].r) words_q.push_back(log_q[k]);
    endtask

    // which: 0 done, 1 rd_en, 2 we, 3 valid, 4 busy; counted over labels lo..hi
    function automatic int count_in(input int which, input int lo, input int hi);
        int cnt = 0;
        foreach (log_q[k]) begin
            if (log_q[k].lbl >= lo && log_q[k].lbl <= hi) begin
                case (which)
                    0:       cnt += int'(log_q[k].dn);
                    1:       cnt += int'(log_q[k].rd);
                    2:       cnt += int'(log_q[k].we);
                    3:       cnt += int'(log_q[k].v);
                    default: cnt += int'(log_q[k].bz);
                endcase
            end
        end
        return cnt;
    endfunction

    function automatic int done_label();
        int l = -1;
        foreach (log_q[k]) if (log_q[k].dn) l = log_q[k].lbl;
        return l;
    endfunction

    int e_i[6] = '{0, 0, 0, 1, 1, 1};
    int e_q[6] = '{0, 1, 2, 0, 1, 2};
    int e_c[6] = '{0, 1, 2, 16, 17, 18};

    task automatic check_2x3(input string t, input int n, input int gap_word1);
        collect();
        chk({t, "_nwords"}, words_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < words_q.size()) begin
                chk($sformatf("%s_i%0d", t, k), words_q[k].i, e_i[k]);
                chk($sformatf("%s_q%0d", t, k), words_q[k].q, e_q[k]);
                chk($sformatf("%s_c%0d", t, k), words_q[k].c, e_c[k]);
                chk($sformatf("%s_cyc%0d", t, k), words_q[k].lbl, n + 3 + 3 * k + (k >= 1 ? gap_word1 : 0));
            end
        end
        chk({t, "_ndone"}, count_in(0, 0, 1 << 30), 1);
        chk({t, "_done_cyc"}, done_label(), n + 19 + gap_word1);
    endtask

    initial begin
        int n;
        int cnt;
        int errs;
        reset = 1'b1; start = 1'b0; clear_after = 1'b0; out_ready = 1'b1;
        i_bin_num = 6'd0; q_bin_num = 6'd0;
        preload = 1'b1;
        tick(); tick();
        preload = 1'b0;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rd", mem_rd_en, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_count", out_count, 0);

        // 1: basic 2x3 dump, ready always high
        log_q.delete(); log_en = 1'b1;
        start_dump(6'd2, 6'd3, 1'b0, n);
        wait_idle("t1_idle", 100);
        check_2x3("t1", n, 0);

        // 2: 5-cycle stall on word (0,1)
        log_q.delete();
        start_dump(6'd2, 6'd3, 1'b0, n);
        repeat (5) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_idle("t2_idle", 100);
        check_2x3("t2", n, 5);
        cnt = 0;
        foreach (log_q[k])
            if (log_q[k].lbl >= n + 6 && log_q[k].lbl <= n + 10 && log_q[k].v &&
                log_q[k].i == 6'd0 && log_q[k].q == 6'd1 && log_q[k].c == 16'd1) cnt++;
        chk("t2_stable", cnt, 5);
        chk("t2_rd_stall", count_in(1, n + 6, n + 10), 0);
        chk("t2_rd_total", count_in(1, 0, 1 << 30), 6);

        // 3: clear-after-read on 2x2, then a second dump sees zeros
        log_q.delete();
        start_dump(6'd2, 6'd2, 1'b1, n);
        wait_idle("t3_idle", 100);
        collect();
        chk("t3_nwords", words_q.size(), 4);
        chk("t3_nwe", count_in(2, 0, 1 << 30), 4);
        cnt = 0;
        foreach (log_q[k]) begin
            if (log_q[k].we) begin
                chk($sformatf("t3_we_cyc%0d", cnt), log_q[k].lbl, n + 4 + 4 * cnt);
                chk($sformatf("t3_we_addr%0d", cnt), log_q[k].a, (cnt >> 1) * 64 + (cnt & 1));
                cnt++;
            end
        end
        if (words_q.size() == 4) begin
            chk("t3_c0", words_q[0].c, 0);
            chk("t3_c1", words_q[1].c, 1);
            chk("t3_c2", words_q[2].c, 16);
            chk("t3_c3", words_q[3].c, 17);
            chk("t3_cyc3", words_q[3].lbl, n + 15);
        end
        log_q.delete();
        start_dump(6'd2, 6'd2, 1'b0, n);
        wait_idle("t3b_idle", 100);
        collect();
        chk("t3b_nwords", words_q.size(), 4);
        cnt = 0;
        foreach (words_q[k]) if (words_q[k].c == 16'd0) cnt++;
        chk("t3b_zeros", cnt, 4);
        chk("t3b_nwe", count_in(2, 0, 1 << 30), 0);

        // 4: zero-sized dump
        log_q.delete();
        start_dump(6'd0, 6'd3, 1'b0, n);
        wait_idle("t4_idle", 20);
        chk("t4_busy_cycles", count_in(4, 0, 1 << 30), 1);
        chk("t4_done_cyc", done_label(), n + 1);
        chk("t4_valid", count_in(3, 0, 1 << 30), 0);
        chk("t4_rd", count_in(1, 0, 1 << 30), 0);

        // 5: reset while presenting the third word
        preload = 1'b1; tick(); preload = 1'b0;
        log_q.delete();
        start_dump(6'd2, 6'd3, 1'b0, n);
        repeat (8) tick();
        chk("t5_in_present", out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        repeat (3) tick();
        chk("t5_no_done", count_in(0, 0, 1 << 30), 0);
        log_q.delete();
        start_dump(6'd2, 6'd3, 1'b0, n);
        wait_idle("t5b_idle", 100);
        check_2x3("t5b", n, 0);

        // 6: start while busy is ignored; then a full 63x63 scan
        log_q.delete();
        start_dump(6'd2, 6'd3, 1'b0, n);
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_idle("t6_idle", 100);
        check_2x3("t6", n, 0);
        chk("t6_no_restart", busy, 0);

        log_q.delete();
        start_dump(6'd63, 6'd63, 1'b0, n);
        wait_idle("t6b_idle", 20000);
        collect();
        chk("t6b_nwords", words_q.size(), 3969);
        errs = 0;
        foreach (words_q[k])
            if (words_q[k].i != 6'(k / 63) || words_q[k].q != 6'(k % 63) ||
                words_q[k].c != 16'(16 * (k / 63) + (k % 63))) errs++;
        chk("t6b_order", errs, 0);
        if (words_q.size() > 0) begin
            chk("t6b_last_i", words_q[words_q.size() - 1].i, 62);
            chk("t6b_last_q", words_q[words_q.size() - 1].q, 62);
            chk("t6b_last_c", words_q[words_q.size() - 1].c, 1054);
        end

        log_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
